sm_lsu: RTL and testbench

//  Load/store unit between the CPU data port and the word-wide data RAM (sm_ram,

---
 rtl/sm_lsu.sv | 133 +++++++++++++
 tb/tb_sm_lsu.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sm_lsu.sv
// Load/store unit between the CPU data port and a word-wide RAM with combinational read.
// Sub-word stores are done as read-modify-write; loads are lane-selected and extended.
module sm_lsu #(
  parameter int WIDTH = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] ram_a,
  output logic        ram_we,
  output logic [31:0] ram_wd,
  input  logic [31:0] ram_rd
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state, state_nx;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [31:0] data_q;

  logic        accept;
  logic        req_err;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] merged;

  assign accept    = req_valid && (state == IDLE);
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign ram_we    = (state == WR) && !rst;
  assign ram_a     = {addr_q[31:2], 2'b00};
  assign ram_wd    = merged;

  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11)                           req_err = 1'b1;
    if ((req_size == 2'b01) && req_addr[0])          req_err = 1'b1;
    if ((req_size == 2'b10) && (req_addr[1:0] != '0)) req_err = 1'b1;
    if (req_addr[31:WIDTH] != '0)                    req_err = 1'b1;
  end

  // Extraction works on ram_rd directly in RD, which is the value data_q captures on the same edge.
  always_comb begin
    ld_byte = ram_rd[{addr_q[1:0], 3'b000} +: 8];
    ld_half = ram_rd[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   ld_data = {{24{signed_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{signed_q & ld_half[15]}}, ld_half};
      default: ld_data = ram_rd;
    endcase
  end

  always_comb begin
    merged = data_q;
    case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                  state_nx = RESP;
          else if (!req_we)             state_nx = RD;
          else if (req_size == 2'b10)   state_nx = WR;
          else                          state_nx = RD;
        end
      end
      RD:      state_nx = we_q ? WR : RESP;
      WR:      state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Response registers change only on the edge entering RESP, so they hold between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      signed_q  <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      data_q    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        addr_q   <= req_addr;
        size_q   <= req_size;
        signed_q <= req_signed;
        we_q     <= req_we;
        wdata_q  <= req_wdata;
        if (req_err) begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end
      end
      if (state == RD) begin
        data_q <= ram_rd;
        if (!we_q) begin
          rsp_rdata <= ld_data;
          rsp_err   <= 1'b0;
        end
      end
      if (state == WR) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sm_lsu.sv
// Self-checking bench for sm_lsu: vector table driven through a scoreboard,
// plus reset-during-write and back-to-back sequences, against a small RAM model.
module tb_sm_lsu;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int unsigned lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] ram_a;
  logic        ram_we;
  logic [31:0] ram_wd;
  logic [31:0] ram_rd;

  logic [31:0] mem [0:15];

  int          nvec = 0;
  int          nmis = 0;
  int          cyc = 0;
  int          we_cnt = 0;
  int          exp_we = 0;
  vec_t        exp_q[$];
  int          acc_q[$];
  vec_t        vt[$];

  always #5 clk = ~clk;

  sm_lsu #(.WIDTH(6)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .ram_a(ram_a), .ram_we(ram_we),
    .ram_wd(ram_wd), .ram_rd(ram_rd)
  );

  assign ram_rd = mem[ram_a[5:2]];
  always @(posedge clk) if (ram_we) mem[ram_a[5:2]] <= ram_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic err, input int unsigned lat);
    vec_t v;
    v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = rdata; v.exp_err = err; v.lat = lat;
    return v;
  endfunction

  // Scoreboard side: handshakes noted on the negedge before the accepting posedge.
  always @(negedge clk) begin
    vec_t e;
    int   a;
    cyc++;
    if (rst) begin
      acc_q.delete();
    end else begin
      if (ram_we) we_cnt++;
      if (rsp_valid) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          nvec++; nmis++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected none (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.exp_rdata);
          chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.exp_err});
          chk("latency", cyc - a, e.lat);
        end
      end
      if (req_valid && req_ready) begin
        chk("accept_while_busy", acc_q.size(), 0);
        acc_q.push_back(cyc);
      end
    end
  end

  task automatic send(input vec_t v, input bit hold);
    int unsigned n;
    bit          rdy;
    req_we = v.we; req_size = v.size; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    exp_q.push_back(v);
    if (v.we && !v.exp_err) exp_we++;
    n = 0;
    do begin
      rdy = req_ready;
      @(posedge clk); #2;
      n++;
    end while (!rdy && n < 50);
    if (!rdy) begin
      nvec++; nmis++;
      $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
    end
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    if (exp_q.size() != 0) begin
      nvec++; nmis++;
      $display("FAIL rsp_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = '0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;

    vt.push_back(mk(1, 2'b10, 0, 32'h08, 32'hDEADBEEF, 32'h0, 0, 2));
    vt.push_back(mk(0, 2'b10, 1, 32'h08, 32'h0, 32'hDEADBEEF, 0, 2));
    vt.push_back(mk(1, 2'b10, 0, 32'h08, 32'h11223344, 32'h0, 0, 2));
    vt.push_back(mk(1, 2'b00, 0, 32'h09, 32'hFFFFFF5A, 32'h0, 0, 3));
    vt.push_back(mk(0, 2'b10, 0, 32'h08, 32'h0, 32'h11225A44, 0, 2));
    vt.push_back(mk(0, 2'b00, 1, 32'h0B, 32'h0, 32'h00000011, 0, 2));
    vt.push_back(mk(1, 2'b00, 0, 32'h09, 32'h00000080, 32'h0, 0, 3));
    vt.push_back(mk(0, 2'b00, 1, 32'h09, 32'h0, 32'hFFFFFF80, 0, 2));
    vt.push_back(mk(0, 2'b00, 0, 32'h09, 32'h0, 32'h00000080, 0, 2));
    vt.push_back(mk(1, 2'b10, 0, 32'h0C, 32'h11223344, 32'h0, 0, 2));
    vt.push_back(mk(1, 2'b01, 0, 32'h0E, 32'hFFFFBEEF, 32'h0, 0, 3));
    vt.push_back(mk(0, 2'b10, 0, 32'h0C, 32'h0, 32'hBEEF3344, 0, 2));
    vt.push_back(mk(0, 2'b01, 1, 32'h0E, 32'h0, 32'hFFFFBEEF, 0, 2));
    vt.push_back(mk(0, 2'b01, 0, 32'h0E, 32'h0, 32'h0000BEEF, 0, 2));
    vt.push_back(mk(0, 2'b01, 1, 32'h0C, 32'h0, 32'h00003344, 0, 2));
    vt.push_back(mk(0, 2'b00, 1, 32'h0C, 32'h0, 32'h00000044, 0, 2));
    vt.push_back(mk(1, 2'b10, 0, 32'h3C, 32'hA5A5A5A5, 32'h0, 0, 2));
    vt.push_back(mk(0, 2'b00, 0, 32'h3F, 32'h0, 32'h000000A5, 0, 2));
    vt.push_back(mk(0, 2'b10, 0, 32'h06, 32'h0, 32'h0, 1, 1));
    vt.push_back(mk(1, 2'b01, 0, 32'h05, 32'h12345678, 32'h0, 1, 1));
    vt.push_back(mk(1, 2'b11, 0, 32'h08, 32'hCAFEF00D, 32'h0, 1, 1));
    vt.push_back(mk(1, 2'b10, 0, 32'h40, 32'hCAFEF00D, 32'h0, 1, 1));
    vt.push_back(mk(0, 2'b00, 0, 32'hFFFFFFF0, 32'h0, 32'h0, 1, 1));
    vt.push_back(mk(0, 2'b01, 1, 32'h03, 32'h0, 32'h0, 1, 1));
    vt.push_back(mk(0, 2'b10, 0, 32'h08, 32'h0, 32'h11228044, 0, 2));
    vt.push_back(mk(0, 2'b10, 0, 32'h0C, 32'h0, 32'hBEEF3344, 0, 2));

    repeat (3) @(posedge clk);
    #2; rst = 1'b0;
    chk("reset_req_ready", {31'b0, req_ready}, 32'h1);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("reset_rsp_err", {31'b0, rsp_err}, 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_ram_we", {31'b0, ram_we}, 32'h0);
    chk("reset_ram_a", ram_a, 32'h0);
    chk("reset_ram_wd", ram_wd, 32'h0);

    foreach (vt[i]) begin
      send(vt[i], 1'b0);
      drain();
    end

    // Reset arrives while the byte store sits in WR: the write must be dropped.
    req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h09; req_wdata = 32'h77; req_valid = 1'b1;
    @(posedge clk); #2; req_valid = 1'b0;
    @(posedge clk); #2;
    chk("wr_state_ram_we", {31'b0, ram_we}, 32'h1);
    rst = 1'b1; #1;
    chk("rst_in_wr_ram_we", {31'b0, ram_we}, 32'h0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b0;
    chk("post_rst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("post_rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    repeat (4) @(posedge clk);
    #2;
    send(mk(0, 2'b10, 0, 32'h08, 32'h0, 32'h11228044, 0, 2), 1'b0);
    drain();

    send(mk(0, 2'b10, 0, 32'h08, 32'h0, 32'h11228044, 0, 2), 1'b1);
    send(mk(0, 2'b10, 1, 32'h0C, 32'h0, 32'hBEEF3344, 0, 2), 1'b1);
    send(mk(0, 2'b00, 1, 32'h0A, 32'h0, 32'h00000022, 0, 2), 1'b0);
    drain();
    repeat (3) @(posedge clk);
    #2;
    chk("rsp_rdata_held", rsp_rdata, 32'h00000022);
    chk("ram_we_pulses", we_cnt, exp_we);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
